// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the MIPS-subset core.
// Walks IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] and drives the datapath strobes.
// The instruction class is latched in DECODE so later states do not depend on the decoder.
// A shared wait counter traps stalled memory handshakes.
// Every retirement pulses pc_write once, so the retired counter simply counts pc_write pulses.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             memread,
  output logic             memwrite,
  output logic             regwrite,
  output logic             reg_dst,
  output logic             immReg,
  output logic [3:0]       aluOp,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             fault,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_AND, C_OR, C_SLT, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_ILL
  } class_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q;
  state_t     state_d;
  class_t     cls_q;
  class_t     cls_dec;
  logic [7:0] wait_cnt;
  logic       is_rtype;
  logic       wait_ack;
  logic       timed_out;

  assign state     = state_q;
  assign is_rtype  = (cls_q == C_ADD) || (cls_q == C_SUB) || (cls_q == C_AND) ||
                     (cls_q == C_OR)  || (cls_q == C_SLT);
  assign wait_ack  = ((state_q == S_FETCH) && imem_ack) || ((state_q == S_MEM) && dmem_ack);
  assign timed_out = (wait_cnt == WAIT_LAST) && !wait_ack;

  // Classify the opcode/funct pair; any encoding outside the subset is illegal.
  always_comb begin
    cls_dec = C_ILL;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20:   cls_dec = C_ADD;
          6'h22:   cls_dec = C_SUB;
          6'h24:   cls_dec = C_AND;
          6'h25:   cls_dec = C_OR;
          6'h2A:   cls_dec = C_SLT;
          default: cls_dec = C_ILL;
        endcase
      end
      6'h08:   cls_dec = C_ADDI;
      6'h23:   cls_dec = C_LW;
      6'h2B:   cls_dec = C_SW;
      6'h04:   cls_dec = C_BEQ;
      6'h02:   cls_dec = C_J;
      default: cls_dec = C_ILL;
    endcase
  end

  // State register; reset parks the FSM in IDLE which decodes to all strobes low.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Latch the instruction class once, in DECODE, while the decoder fields are valid.
  always_ff @(posedge clk) begin
    if (rst)                      cls_q <= C_ILL;
    else if (state_q == S_DECODE) cls_q <= cls_dec;
  end

  // Wait counter restarts on every entry to a handshake state and counts unacked cycles.
  always_ff @(posedge clk) begin
    if (rst)
      wait_cnt <= 8'd0;
    else if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)))
      wait_cnt <= 8'd0;
    else if (((state_q == S_FETCH) || (state_q == S_MEM)) && !wait_ack)
      wait_cnt <= wait_cnt + 8'd1;
  end

  // Retired count advances on each pc_write, which happens exactly once per instruction.
  always_ff @(posedge clk) begin
    if (rst)           retired <= '0;
    else if (pc_write) retired <= retired + 1'b1;
  end

  // Next-state and strobe decode from the current state and latched class.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    dmem_req = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    reg_dst  = 1'b0;
    immReg   = 1'b0;
    aluOp    = 4'b0000;
    pc_write = 1'b0;
    pc_src   = 2'b00;
    fault    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        state_d = (cls_dec == C_ILL) ? S_FAULT : S_EXEC;
      end
      S_EXEC: begin
        case (cls_q)
          C_ADD: begin aluOp = 4'b0000; state_d = S_WB; end
          C_SUB: begin aluOp = 4'b0001; state_d = S_WB; end
          C_AND: begin aluOp = 4'b0010; state_d = S_WB; end
          C_OR:  begin aluOp = 4'b0011; state_d = S_WB; end
          C_SLT: begin aluOp = 4'b0100; state_d = S_WB; end
          C_ADDI: begin
            immReg  = 1'b1;
            state_d = S_WB;
          end
          C_LW, C_SW: begin
            immReg  = 1'b1;
            state_d = S_MEM;
          end
          C_BEQ: begin
            aluOp    = 4'b0001;
            pc_write = 1'b1;
            pc_src   = alu_zero ? 2'b01 : 2'b00;
            state_d  = S_FETCH;
          end
          C_J: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            state_d  = S_FETCH;
          end
          default: state_d = S_FAULT;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        memread  = (cls_q == C_LW);
        memwrite = (cls_q == C_SW);
        if (dmem_ack) begin
          if (cls_q == C_LW) begin
            state_d = S_WB;
          end else begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
        end else if (timed_out) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        regwrite = 1'b1;
        reg_dst  = is_rtype;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: state_d = S_FAULT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table plus hand-written
// sequences for timeouts, ack-vs-timeout priority and reset during a memory access.
// A narrow-counter copy of the DUT follows the same stimulus to exercise counter wrap.
module tb_multicycle_control;

  typedef struct {
    logic       rst;
    logic       run;
    logic [5:0] op;
    logic [5:0] fn;
    logic       az;
    logic       ia;
    logic       da;
    logic [2:0] st;
    logic [9:0] stb;
    logic [3:0] alu;
    logic [1:0] pcs;
    int         ret;
  } vec_t;

  // Strobe bits: imem_req ir_load dmem_req memread memwrite regwrite reg_dst immReg pc_write fault
  localparam logic [9:0] IREQ = 10'b1000000000;
  localparam logic [9:0] IRL  = 10'b0100000000;
  localparam logic [9:0] DREQ = 10'b0010000000;
  localparam logic [9:0] MRD  = 10'b0001000000;
  localparam logic [9:0] MWR  = 10'b0000100000;
  localparam logic [9:0] RW   = 10'b0000010000;
  localparam logic [9:0] RDST = 10'b0000001000;
  localparam logic [9:0] IMM  = 10'b0000000100;
  localparam logic [9:0] PCW  = 10'b0000000010;
  localparam logic [9:0] FLT  = 10'b0000000001;

  logic        clk;
  logic        rst;
  logic        run;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        alu_zero;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req, ir_load, dmem_req, memread, memwrite, regwrite, reg_dst, immReg;
  logic [3:0]  aluOp;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        fault;
  logic [15:0] retired;
  logic [2:0]  state;

  logic        n_imem_req, n_ir_load, n_dmem_req, n_memread, n_memwrite, n_regwrite;
  logic        n_reg_dst, n_immReg, n_pc_write, n_fault;
  logic [3:0]  n_aluOp;
  logic [1:0]  n_pc_src;
  logic [2:0]  n_retired;
  logic [2:0]  n_state;

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req),
    .memread(memread), .memwrite(memwrite), .regwrite(regwrite),
    .reg_dst(reg_dst), .immReg(immReg), .aluOp(aluOp), .pc_write(pc_write),
    .pc_src(pc_src), .fault(fault), .retired(retired), .state(state)
  );

  multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(3)) dut_narrow (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(n_imem_req), .ir_load(n_ir_load), .dmem_req(n_dmem_req),
    .memread(n_memread), .memwrite(n_memwrite), .regwrite(n_regwrite),
    .reg_dst(n_reg_dst), .immReg(n_immReg), .aluOp(n_aluOp), .pc_write(n_pc_write),
    .pc_src(n_pc_src), .fault(n_fault), .retired(n_retired), .state(n_state)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s #%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the falling edge, then let them settle.
  task automatic applyStimulus(input logic r, input logic rn, input logic [5:0] op,
                               input logic [5:0] fn, input logic az, input logic ia,
                               input logic da);
    @(negedge clk);
    rst      = r;
    run      = rn;
    opcode   = op;
    funct    = fn;
    alu_zero = az;
    imem_ack = ia;
    dmem_ack = da;
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic addVec(input logic r, input logic rn, input logic [5:0] op, input logic [5:0] fn,
                        input logic az, input logic ia, input logic da, input logic [2:0] st,
                        input logic [9:0] stb, input logic [3:0] alu, input logic [1:0] pcs,
                        input int ret);
    vec_t v;
    v.rst = r; v.run = rn; v.op = op; v.fn = fn; v.az = az; v.ia = ia; v.da = da;
    v.st = st; v.stb = stb; v.alu = alu; v.pcs = pcs; v.ret = ret;
    vecs.push_back(v);
  endtask

  task automatic addFetch(input logic [5:0] op, input int ret);
    addVec(0, 0, op, 6'h00, 0, 1, 0, 3'd1, IREQ | IRL, 4'd0, 2'b00, ret);
  endtask

  task automatic addRtype(input logic [5:0] fn, input logic [3:0] alu, input int ret);
    addFetch(6'h00, ret);
    addVec(0, 0, 6'h00, fn, 0, 0, 0, 3'd2, 10'd0, 4'd0, 2'b00, ret);
    addVec(0, 0, 6'h00, fn, 0, 0, 0, 3'd3, 10'd0, alu, 2'b00, ret);
    addVec(0, 0, 6'h00, fn, 0, 0, 0, 3'd5, RW | RDST | PCW, 4'd0, 2'b00, ret);
  endtask

  initial begin
    vec_t v;
    int   req_cycles;

    rst = 1'b1; run = 1'b0; opcode = 6'h00; funct = 6'h00;
    alu_zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) addVec(0, 0, 6'h00, 6'h00, 0, 0, 0, 3'd0, 10'd0, 4'd0, 2'b00, 0);
    // add with zero-wait fetch.
    addVec(0, 1, 6'h00, 6'h20, 0, 0, 0, 3'd0, 10'd0, 4'd0, 2'b00, 0);
    addRtype(6'h20, 4'd0, 0);
    // lw, three wait cycles on data memory.
    addFetch(6'h23, 1);
    addVec(0, 0, 6'h23, 6'h00, 0, 0, 0, 3'd2, 10'd0, 4'd0, 2'b00, 1);
    addVec(0, 0, 6'h23, 6'h00, 0, 0, 0, 3'd3, IMM, 4'd0, 2'b00, 1);
    for (int i = 0; i < 3; i++) addVec(0, 0, 6'h23, 6'h00, 0, 0, 0, 3'd4, DREQ | MRD, 4'd0, 2'b00, 1);
    addVec(0, 0, 6'h23, 6'h00, 0, 0, 1, 3'd4, DREQ | MRD, 4'd0, 2'b00, 1);
    addVec(0, 0, 6'h23, 6'h00, 0, 0, 0, 3'd5, RW | PCW, 4'd0, 2'b00, 1);
    // beq taken, then not taken.
    addFetch(6'h04, 2);
    addVec(0, 0, 6'h04, 6'h00, 1, 0, 0, 3'd2, 10'd0, 4'd0, 2'b00, 2);
    addVec(0, 0, 6'h04, 6'h00, 1, 0, 0, 3'd3, PCW, 4'd1, 2'b01, 2);
    addFetch(6'h04, 3);
    addVec(0, 0, 6'h04, 6'h00, 0, 0, 0, 3'd2, 10'd0, 4'd0, 2'b00, 3);
    addVec(0, 0, 6'h04, 6'h00, 0, 0, 0, 3'd3, PCW, 4'd1, 2'b00, 3);
    // sw, zero-wait data memory.
    addFetch(6'h2B, 4);
    addVec(0, 0, 6'h2B, 6'h00, 0, 0, 0, 3'd2, 10'd0, 4'd0, 2'b00, 4);
    addVec(0, 0, 6'h2B, 6'h00, 0, 0, 0, 3'd3, IMM, 4'd0, 2'b00, 4);
    addVec(0, 0, 6'h2B, 6'h00, 0, 0, 1, 3'd4, DREQ | MWR | PCW, 4'd0, 2'b00, 4);
    // j with one fetch wait cycle.
    addVec(0, 0, 6'h02, 6'h00, 0, 0, 0, 3'd1, IREQ, 4'd0, 2'b00, 5);
    addFetch(6'h02, 5);
    addVec(0, 0, 6'h02, 6'h00, 0, 0, 0, 3'd2, 10'd0, 4'd0, 2'b00, 5);
    addVec(0, 0, 6'h02, 6'h00, 0, 0, 0, 3'd3, PCW, 4'd0, 2'b10, 5);
    // addi, with stray acks in DECODE.
    addFetch(6'h08, 6);
    addVec(0, 0, 6'h08, 6'h00, 0, 1, 1, 3'd2, 10'd0, 4'd0, 2'b00, 6);
    addVec(0, 0, 6'h08, 6'h00, 0, 0, 0, 3'd3, IMM, 4'd0, 2'b00, 6);
    addVec(0, 0, 6'h08, 6'h00, 0, 0, 0, 3'd5, RW | PCW, 4'd0, 2'b00, 6);
    // Remaining R-type ALU ops; narrow counter wraps 7 -> 0 here.
    addRtype(6'h22, 4'd1, 7);
    addRtype(6'h2A, 4'd4, 8);
    addRtype(6'h24, 4'd2, 9);
    addRtype(6'h25, 4'd3, 10);
    // Illegal funct traps; run and acks ignored while faulted.
    addFetch(6'h00, 11);
    addVec(0, 0, 6'h00, 6'h21, 0, 0, 0, 3'd2, 10'd0, 4'd0, 2'b00, 11);
    addVec(0, 1, 6'h00, 6'h21, 0, 1, 1, 3'd7, FLT, 4'd0, 2'b00, 11);
    addVec(0, 0, 6'h00, 6'h21, 0, 0, 0, 3'd7, FLT, 4'd0, 2'b00, 11);
    addVec(1, 0, 6'h00, 6'h00, 0, 0, 0, 3'd7, FLT, 4'd0, 2'b00, 11);
    addVec(0, 0, 6'h00, 6'h00, 0, 0, 0, 3'd0, 10'd0, 4'd0, 2'b00, 0);
    // Illegal opcode 3F traps after DECODE.
    addVec(0, 1, 6'h3F, 6'h00, 0, 0, 0, 3'd0, 10'd0, 4'd0, 2'b00, 0);
    addFetch(6'h3F, 0);
    addVec(0, 0, 6'h3F, 6'h00, 0, 0, 0, 3'd2, 10'd0, 4'd0, 2'b00, 0);
    addVec(0, 0, 6'h3F, 6'h00, 0, 0, 0, 3'd7, FLT, 4'd0, 2'b00, 0);
    addVec(0, 1, 6'h3F, 6'h00, 0, 1, 0, 3'd7, FLT, 4'd0, 2'b00, 0);

    doReset();
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(v.rst, v.run, v.op, v.fn, v.az, v.ia, v.da);
      checkOutput("state", i, 32'(state), 32'(v.st));
      checkOutput("strobes", i,
                  32'({imem_req, ir_load, dmem_req, memread, memwrite, regwrite, reg_dst,
                       immReg, pc_write, fault}), 32'(v.stb));
      checkOutput("alu_pcsrc", i, 32'({aluOp, pc_src}), 32'({v.alu, v.pcs}));
      checkOutput("retired", i, 32'(retired), 32'(v.ret[15:0]));
      checkOutput("retired_wrap", i, 32'(n_retired), 32'(v.ret[2:0]));
    end

    // Instruction fetch never acked: fault after exactly 15 request cycles.
    doReset();
    applyStimulus(0, 1, 6'h00, 6'h20, 0, 0, 0);
    req_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(0, 0, 6'h00, 6'h20, 0, 0, 0);
      if (state == 3'd7) break;
      if (imem_req) req_cycles++;
    end
    checkOutput("imem_timeout_cycles", 0, 32'(req_cycles), 32'd15);
    checkOutput("imem_timeout_fault", 0, 32'(fault), 32'd1);

    // Ack on the final allowed cycle wins over the timeout.
    doReset();
    applyStimulus(0, 1, 6'h00, 6'h20, 0, 0, 0);
    for (int c = 0; c < 14; c++) applyStimulus(0, 0, 6'h00, 6'h20, 0, 0, 0);
    applyStimulus(0, 0, 6'h00, 6'h20, 0, 1, 0);
    checkOutput("ack_priority_irload", 0, 32'(ir_load), 32'd1);
    applyStimulus(0, 0, 6'h00, 6'h20, 0, 0, 0);
    checkOutput("ack_priority_state", 0, 32'(state), 32'd2);

    // Data memory never acked on lw: fault after 15 request cycles.
    doReset();
    applyStimulus(0, 1, 6'h23, 6'h00, 0, 0, 0);
    applyStimulus(0, 0, 6'h23, 6'h00, 0, 1, 0);
    applyStimulus(0, 0, 6'h23, 6'h00, 0, 0, 0);
    applyStimulus(0, 0, 6'h23, 6'h00, 0, 0, 0);
    req_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      if (state == 3'd7) break;
      if (dmem_req) req_cycles++;
      applyStimulus(0, 0, 6'h23, 6'h00, 0, 0, 0);
    end
    checkOutput("dmem_timeout_cycles", 0, 32'(req_cycles), 32'd15);
    checkOutput("dmem_timeout_fault", 0, 32'(fault), 32'd1);

    // Reset during MEM drops the data request on the following cycle.
    doReset();
    applyStimulus(0, 1, 6'h23, 6'h00, 0, 0, 0);
    applyStimulus(0, 0, 6'h23, 6'h00, 0, 1, 0);
    applyStimulus(0, 0, 6'h23, 6'h00, 0, 0, 0);
    applyStimulus(0, 0, 6'h23, 6'h00, 0, 0, 0);
    applyStimulus(1, 0, 6'h23, 6'h00, 0, 0, 0);
    checkOutput("mem_before_rst", 0, 32'({dmem_req, memread}), 32'b11);
    applyStimulus(0, 0, 6'h23, 6'h00, 0, 0, 0);
    checkOutput("mem_after_rst_req", 0, 32'(dmem_req), 32'd0);
    checkOutput("mem_after_rst_state", 0, 32'(state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
